// File: rtl/et_err_pkg.sv
// Shared definitions for the single-wire error-bus link (transmitter and receiver).
package et_err_pkg;

  localparam int LENGTH_ERR_DEF = 232;  // payload bits per frame, headers excluded
  localparam int GAP_LEN_DEF    = 3;    // idle zero bits after every frame
  localparam int HDR_LEN        = 3;    // header bits per frame

  // Headers are driven MSB first.
  localparam logic [HDR_LEN-1:0] HDR_TLK = 3'b100;
  localparam logic [HDR_LEN-1:0] HDR_DC  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    GAP
  } err_state_e;

endpackage

// File: rtl/et_err_shreg.sv
// Load / shift-right register holding the payload word in flight; lsb is the next bit out.
module et_err_shreg #(
  parameter int WIDTH = 232
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Load has priority over shift; zeros fill from the top.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb = sr_q[0];

endmodule

// File: rtl/et_err_tx.sv
// Error-bus link transmitter: serializes TLK and DC error words as
// header (MSB first) + payload (LSB first) + zero gap, one bit per clock.
//
// Handshake: a word is taken on a rising edge where *_valid and *_ready are
// both high; *_ready depends on state only, the bus is sampled at that edge
// alone and valid may be held or dropped freely otherwise. TLK wins ties.
module et_err_tx
  import et_err_pkg::*;
#(
  parameter int LENGTH_ERR = LENGTH_ERR_DEF,
  parameter int GAP_LEN    = GAP_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LENGTH_ERR-1:0] tlk_err_bus,
  input  logic                  tlk_valid,
  output logic                  tlk_ready,
  input  logic [LENGTH_ERR-1:0] dc_err_bus,
  input  logic                  dc_valid,
  output logic                  dc_ready,
  output logic                  out_live,
  output logic                  out_err,
  output logic                  busy,
  output logic                  tlk_sent,
  output logic                  dc_sent
);

  if (LENGTH_ERR < 2 || LENGTH_ERR > 255) begin : g_bad_length
    $error("et_err_tx: LENGTH_ERR must be 2..255 for the 8-bit counter");
  end
  if (GAP_LEN < 3 || GAP_LEN > 15) begin : g_bad_gap
    $error("et_err_tx: GAP_LEN must be 3..15");
  end

  localparam logic [7:0] LAST_HDR = 8'(HDR_LEN - 1);
  localparam logic [7:0] LAST_BIT = 8'(LENGTH_ERR - 1);
  // The final gap bit is driven while already back in IDLE, so a waiting
  // word can be accepted flush with the end of the gap.
  localparam logic [7:0] LAST_GAP = 8'(GAP_LEN - 2);

  err_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_dc_q, is_dc_d;
  logic       tail_q, tail_d;
  logic       out_err_q, out_err_d;
  logic       out_live_q;
  logic       busy_q, busy_d;
  logic       tlk_sent_q, tlk_sent_d;
  logic       dc_sent_q, dc_sent_d;

  logic                  ready;
  logic                  tlk_go, dc_go;
  logic                  sh_load, sh_shift, sh_lsb;
  logic [LENGTH_ERR-1:0] load_word;
  logic [HDR_LEN-1:0]    hdr_cur;
  logic [1:0]            hdr_idx;

  assign ready     = (state_q == IDLE) && out_live_q;
  assign tlk_go    = tlk_valid && ready;
  assign dc_go     = dc_valid && ready && !tlk_valid;
  assign load_word = tlk_go ? tlk_err_bus : dc_err_bus;
  assign hdr_cur   = is_dc_q ? HDR_DC : HDR_TLK;
  assign hdr_idx   = 2'(HDR_LEN - 1) - cnt_q[1:0];

  et_err_shreg #(.WIDTH(LENGTH_ERR)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (load_word),
    .lsb   (sh_lsb)
  );

  // Next state, counter and next registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_dc_d    = is_dc_q;
    tail_d     = 1'b0;
    out_err_d  = 1'b0;
    tlk_sent_d = 1'b0;
    dc_sent_d  = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tlk_go || dc_go) begin
          state_d = HDR;
          cnt_d   = '0;
          is_dc_d = !tlk_go;
          sh_load = 1'b1;
        end
      end
      HDR: begin
        out_err_d = hdr_cur[hdr_idx];
        if (cnt_q == LAST_HDR) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PAYLOAD: begin
        out_err_d = sh_lsb;
        sh_shift  = 1'b1;
        if (cnt_q == LAST_BIT) begin
          tlk_sent_d = !is_dc_q;
          dc_sent_d  = is_dc_q;
          state_d    = GAP;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = IDLE;
          cnt_d   = '0;
          tail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy follows out_err: it covers the last gap bit driven from IDLE.
  always_comb begin
    busy_d = (state_q != IDLE) || tail_q;
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_dc_q    <= 1'b0;
      tail_q     <= 1'b0;
      out_err_q  <= 1'b0;
      out_live_q <= 1'b0;
      busy_q     <= 1'b0;
      tlk_sent_q <= 1'b0;
      dc_sent_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_dc_q    <= is_dc_d;
      tail_q     <= tail_d;
      out_err_q  <= out_err_d;
      out_live_q <= 1'b1;
      busy_q     <= busy_d;
      tlk_sent_q <= tlk_sent_d;
      dc_sent_q  <= dc_sent_d;
    end
  end

  assign tlk_ready = ready;
  assign dc_ready  = ready;
  assign out_live  = out_live_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;
  assign tlk_sent  = tlk_sent_q;
  assign dc_sent   = dc_sent_q;

endmodule

// File: tb/tb_et_err_tx.sv
// Bench for et_err_tx: randomized words, frame-level reference model and
// an expected-frame queue drained by an independent monitor.
module tb_et_err_tx;

  localparam int L = 232;         // payload bits
  localparam int G = 3;           // gap bits
  localparam int F = 3 + L + G;   // out_err cycles per frame

  logic         clk;
  logic         rst;
  logic [L-1:0] tlk_err_bus, dc_err_bus;
  logic         tlk_valid, dc_valid;
  logic         tlk_ready, dc_ready;
  logic         out_live, out_err, busy, tlk_sent, dc_sent;

  et_err_tx #(.LENGTH_ERR(L), .GAP_LEN(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .tlk_err_bus (tlk_err_bus),
    .tlk_valid   (tlk_valid),
    .tlk_ready   (tlk_ready),
    .dc_err_bus  (dc_err_bus),
    .dc_valid    (dc_valid),
    .dc_ready    (dc_ready),
    .out_live    (out_live),
    .out_err     (out_err),
    .busy        (busy),
    .tlk_sent    (tlk_sent),
    .dc_sent     (dc_sent)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: {is_dc, word} per accepted frame, plus the edge count at
  // which its *_sent pulse must be visible.
  logic [L:0] exp_q[$];
  int         exp_t_q[$];

  // Reference model: the two most recent frames, by handshake edge number.
  int           rel = 0;        // rising edges since reset release
  int           cur_t = -1000;
  int           prev_t = -1000;
  logic         cur_kind = 1'b0, prev_kind = 1'b0;
  logic [L-1:0] cur_w = '0, prev_w = '0;
  int           n_acc_tlk = 0;
  int           n_acc_dc = 0;

  logic [L+2:0] win = '0;       // last L+3 out_err bits, oldest at bit 0

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rel <= 0;
    else     rel <= rel + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @rel=%0d: got %b want %b", name, rel, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @rel=%0d: got %h want %h", name, rel, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @rel=%0d: got %0d want %0d", name, rel, act, exp);
    end
  endtask

  // Line value r edges after a handshake at edge t.
  function automatic logic fbit(input int t, input logic kind, input logic [L-1:0] w, input int r);
    int           o;
    logic [2:0]   hdr;
    logic [L-1:0] sh;
    o   = r - t;
    hdr = kind ? 3'b101 : 3'b100;
    sh  = '0;
    if (o == 1) return hdr[2];
    if (o == 2) return hdr[1];
    if (o == 3) return hdr[0];
    if (o >= 4 && o <= L + 3) begin
      sh = w >> (o - 4);
      return sh[0];
    end
    return 1'b0;
  endfunction

  function automatic logic fbusy(input int t, input int r);
    return (r - t >= 1) && (r - t <= F);
  endfunction

  function automatic logic fsent(input int t, input logic kind, input logic want, input int r);
    return (r - t == L + 3) && (kind == want);
  endfunction

  function automatic logic [L-1:0] rand_word();
    logic [255:0] tmp;
    for (int i = 0; i < 8; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[L-1:0];
  endfunction

  // ---------------- reference model + per-cycle checks ----------------
  always @(negedge clk) begin
    logic e_live, e_ready, e_err, e_busy, e_ts, e_ds;
    e_live  = (rel >= 1);
    e_ready = e_live && (rel >= cur_t + F - 1);
    e_err   = fbit(cur_t, cur_kind, cur_w, rel) | fbit(prev_t, prev_kind, prev_w, rel);
    e_busy  = fbusy(cur_t, rel) | fbusy(prev_t, rel);
    e_ts    = fsent(cur_t, cur_kind, 1'b0, rel) | fsent(prev_t, prev_kind, 1'b0, rel);
    e_ds    = fsent(cur_t, cur_kind, 1'b1, rel) | fsent(prev_t, prev_kind, 1'b1, rel);
    chk1("out_live", out_live, e_live);
    chk1("tlk_ready", tlk_ready, e_ready);
    chk1("dc_ready", dc_ready, e_ready);
    chk1("out_err", out_err, e_err);
    chk1("busy", busy, e_busy);
    chk1("tlk_sent", tlk_sent, e_ts);
    chk1("dc_sent", dc_sent, e_ds);
    if (rst) begin
      cur_t  = -1000;
      prev_t = -1000;
      exp_q.delete();
      exp_t_q.delete();
    end else if (e_ready && (tlk_valid || dc_valid)) begin
      prev_t    = cur_t;
      prev_kind = cur_kind;
      prev_w    = cur_w;
      cur_t     = rel + 1;
      cur_kind  = !tlk_valid;
      cur_w     = tlk_valid ? tlk_err_bus : dc_err_bus;
      exp_q.push_back({cur_kind, cur_w});
      exp_t_q.push_back(cur_t + L + 3);
      if (tlk_valid) n_acc_tlk++;
      else           n_acc_dc++;
    end
  end

  // ---------------- monitor: rebuild frame at each *_sent pulse ----------------
  always @(negedge clk) begin
    logic [L:0] e;
    int         et;
    if (rst) begin
      win = '0;
    end else begin
      win = {out_err, win[L+2:1]};
      if (tlk_sent || dc_sent) begin
        chk1("sent_expected", exp_q.size() > 0, 1'b1);
        chk1("sent_onehot", tlk_sent & dc_sent, 1'b0);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          chk1("frame_kind", dc_sent, e[L]);
          chki("frame_hdr", int'({win[0], win[1], win[2]}), e[L] ? 5 : 4);
          chkw("frame_payload", win[L+2:3], e[L-1:0]);
          chki("frame_time", rel, et);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!tlk_valid) tlk_err_bus = rand_word();
      if (!dc_valid)  dc_err_bus  = rand_word();
    end
  endtask

  // Offer words and hold valid until the model records each handshake.
  task automatic drive(input bit do_t, input logic [L-1:0] tw, input bit do_d, input logic [L-1:0] dw);
    bit need_t, need_d;
    int st, sd, k;
    need_t = do_t;
    need_d = do_d;
    st = n_acc_tlk;
    sd = n_acc_dc;
    if (do_t) tlk_err_bus = tw;
    if (do_d) dc_err_bus  = dw;
    tlk_valid = do_t;
    dc_valid  = do_d;
    k = 0;
    while ((need_t || need_d) && k < 800) begin
      @(posedge clk);
      #1;
      k++;
      if (need_t && n_acc_tlk != st) begin need_t = 0; tlk_valid = 1'b0; end
      if (need_d && n_acc_dc != sd)  begin need_d = 0; dc_valid  = 1'b0; end
      if (!tlk_valid) tlk_err_bus = rand_word();
      if (!dc_valid)  dc_err_bus  = rand_word();
    end
    tlk_valid = 1'b0;
    dc_valid  = 1'b0;
    chki("handshake_timeout", int'({need_t, need_d}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [L-1:0] w_a, w_b;
    rst = 1'b1;
    tlk_valid = 1'b0;
    dc_valid  = 1'b0;
    tlk_err_bus = '0;
    dc_err_bus  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset release and quiet idle line.
    idle(20);

    // Single TLK frame carrying 1.
    w_a = '0;
    w_a[0] = 1'b1;
    drive(1, w_a, 0, '0);
    idle(F + 5);

    // Simultaneous TLK/DC: TLK first, DC follows flush.
    w_a = {116{2'b10}};
    w_b = {116{2'b01}};
    drive(1, w_a, 1, w_b);
    idle(F + 5);

    // Reset while payload bit 100 of an all-ones word is on the line.
    drive(1, '1, 0, '0);
    repeat (104) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("rst_async_out_err", out_err, 1'b0);
    chk1("rst_async_out_live", out_live, 1'b0);
    chk1("rst_async_busy", busy, 1'b0);
    chk1("rst_async_tlk_sent", tlk_sent, 1'b0);
    chk1("rst_async_tlk_ready", tlk_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    drive(1, rand_word(), 0, '0);
    idle(F + 5);

    // All-ones words on both buses, back to back.
    drive(1, '1, 1, '1);
    idle(F + 5);

    // Back-to-back TLK frames, then random mix with random spacing.
    drive(1, rand_word(), 0, '0);
    drive(1, rand_word(), 0, '0);
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       drive(1, rand_word(), 0, '0);
        1:       drive(0, '0, 1, rand_word());
        default: drive(1, rand_word(), 1, rand_word());
      endcase
      idle($urandom_range(0, 5));
    end
    idle(F + 10);

    chki("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
